sram_store_buffer: RTL

- Small in-order store buffer directly upstream of the write port (port 1) of the shared true-dual-port data SRAM.
- Accepts byte-masked stores from the pipeline, coalesces back-to-back stores to the same word, and drains one entry per granted cycle into the SRAM write port.
- Forwards buffered bytes into the 1-cycle-latency port-0 read data, so loads always see the newest data.

---
 rtl/sram_store_buffer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sram_store_buffer.sv
// In-order store buffer in front of SRAM write port 1. It coalesces stores to the youngest
// entry, drains one entry per grant, and forwards buffered bytes into port-0 load data.
module sram_store_buffer #(
   parameter  int DATA_WIDTH = 32,
   parameter  int DATA_DEPTH = 1024,
   parameter  int BYTE_SIZE  = 8,
   parameter  int SB_DEPTH   = 4,
   localparam int AW         = $clog2(DATA_DEPTH),
   localparam int NB         = DATA_WIDTH / BYTE_SIZE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_valid_i,
   output logic                  push_ready_o,
   input  logic [AW-1:0]         push_addr_i,
   input  logic [NB-1:0]         push_strb_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  ram_gnt_i,
   output logic                  ram_en_o,
   output logic [NB-1:0]         ram_we_o,
   output logic [AW-1:0]         ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   input  logic                  fwd_valid_i,
   input  logic [AW-1:0]         fwd_addr_i,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i,
   output logic [DATA_WIDTH-1:0] ld_data_o,
   output logic [NB-1:0]         ld_fwd_mask_o,
   output logic                  empty_o
);
   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [AW-1:0]         addr;
      logic [NB-1:0]         strb;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t                ent_q [SB_DEPTH];
   logic [PW-1:0]         head_q, tail_q, yng;
   logic [CW-1:0]         count_q;
   logic [DATA_WIDTH-1:0] fwd_data_q;

   logic                  drain, hit, push_fire, coal, alloc;
   entry_t                head, merged, new_ent;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [NB-1:0]         sel_mask;

   always_comb begin
      head      = ent_q[head_q];
      yng       = tail_q - PW'(1);
      empty_o   = (count_q == '0);
      drain     = !empty_o && ram_gnt_i;
      hit       = !empty_o && (push_addr_i == ent_q[yng].addr);
      // Ready ignores the grant; a full buffer can always take a same-address store.
      push_ready_o = (count_q < CW'(SB_DEPTH)) || hit;
      push_fire = push_valid_i && push_ready_o;
      // Never merge into an entry that is leaving through port 1 this cycle.
      coal      = push_fire && hit && !(drain && count_q == CW'(1));
      alloc     = push_fire && !coal;

      ram_en_o    = drain;
      ram_we_o    = drain ? head.strb : '0;
      ram_addr_o  = head.addr;
      ram_wdata_o = head.data;

      new_ent.addr = push_addr_i;
      new_ent.strb = push_strb_i;
      new_ent.data = push_data_i;
      merged       = ent_q[yng];
      merged.strb  = merged.strb | push_strb_i;
      for (int b = 0; b < NB; b++)
         if (push_strb_i[b])
            merged.data[b*BYTE_SIZE +: BYTE_SIZE] = push_data_i[b*BYTE_SIZE +: BYTE_SIZE];
   end

   // Oldest to youngest, so later sources overwrite earlier ones; the push is youngest.
   always_comb begin
      sel_data = '0;
      sel_mask = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (CW'(i) < count_q && ent_q[head_q + PW'(i)].addr == fwd_addr_i) begin
            for (int b = 0; b < NB; b++) begin
               if (ent_q[head_q + PW'(i)].strb[b]) begin
                  sel_data[b*BYTE_SIZE +: BYTE_SIZE] = ent_q[head_q + PW'(i)].data[b*BYTE_SIZE +: BYTE_SIZE];
                  sel_mask[b] = 1'b1;
               end
            end
         end
      end
      if (push_fire && push_addr_i == fwd_addr_i) begin
         for (int b = 0; b < NB; b++) begin
            if (push_strb_i[b]) begin
               sel_data[b*BYTE_SIZE +: BYTE_SIZE] = push_data_i[b*BYTE_SIZE +: BYTE_SIZE];
               sel_mask[b] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SB_DEPTH; i++) ent_q[i] <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         fwd_data_q    <= '0;
         ld_fwd_mask_o <= '0;
      end else begin
         if (drain) head_q <= head_q + PW'(1);
         if (alloc) begin
            ent_q[tail_q] <= new_ent;
            tail_q        <= tail_q + PW'(1);
         end
         if (coal) ent_q[yng] <= merged;
         count_q       <= count_q + CW'(alloc) - CW'(drain);
         fwd_data_q    <= sel_data;
         ld_fwd_mask_o <= fwd_valid_i ? sel_mask : '0;
      end
   end

   always_comb begin
      ld_data_o = ram_rdata_i;
      for (int b = 0; b < NB; b++)
         if (ld_fwd_mask_o[b])
            ld_data_o[b*BYTE_SIZE +: BYTE_SIZE] = fwd_data_q[b*BYTE_SIZE +: BYTE_SIZE];
   end

endmodule
